// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between the pipeline MEM stage and a loader/debug requester.
// Optional macro ARB_STARVE_GUARD_EN adds a starvation guard that forces a loader slot.
module ram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p_valid,
    input  logic       p_we,
    input  logic [7:0] p_addr,
    input  logic [7:0] p_wdata,
    input  logic       l_req,
    input  logic       l_we,
    input  logic [7:0] l_addr,
    input  logic [7:0] l_wdata,
    output logic       l_gnt,
    output logic [7:0] l_rdata,
    output logic       l_rvalid,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic       stall
);

    logic p_own;
    logic l_own;

`ifdef ARB_STARVE_GUARD_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_FORCE
    } state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t     state_reg;
    logic [2:0] cnt_reg;
    logic       stall_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 3'd0;
            stall_reg <= 1'b0;
        end else begin
            stall_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (p_valid && l_req) begin
                        cnt_reg <= 3'd1;
                        // A limit of one means the very first denial already earns a slot
                        if (LIMIT == 3'd1) begin
                            state_reg <= ST_FORCE;
                            stall_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!l_req || !p_valid) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= 3'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 3'd1;
                        if (cnt_reg + 3'd1 == LIMIT) begin
                            state_reg <= ST_FORCE;
                            stall_reg <= 1'b1;
                        end
                    end
                end
                ST_FORCE: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= 3'd0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        p_own = 1'b0;
        l_own = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                p_own = p_valid;
                l_own = l_req && !p_valid;
            end
            ST_WAIT: begin
                // A dropped request in WAIT is a protocol violation: no loader grant
                p_own = p_valid;
                l_own = l_req && !p_valid;
            end
            ST_FORCE: begin
                l_own = 1'b1;
            end
            default: begin
                p_own = 1'b0;
                l_own = 1'b0;
            end
        endcase
    end

    assign stall = stall_reg && !rst;
`else
    always_comb begin
        p_own = p_valid;
        l_own = l_req && !p_valid;
    end

    assign stall = 1'b0;
`endif

    assign l_gnt = l_own && !rst;

    // RAM port follows the owner combinationally; idle or reset drives all zeros
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = 8'd0;
        ram_wdata = 8'd0;
        if (!rst) begin
            if (l_own) begin
                ram_we    = l_we;
                ram_addr  = l_addr;
                ram_wdata = l_we ? l_wdata : 8'd0;
            end else if (p_own) begin
                ram_we    = p_we;
                ram_addr  = p_addr;
                ram_wdata = p_we ? p_wdata : 8'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_rdata  <= 8'd0;
            l_rvalid <= 1'b0;
        end else begin
            l_rvalid <= l_gnt && !l_we;
            if (l_gnt && !l_we) begin
                l_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Table-driven bench for ram_arbiter with a scoreboard for loader read returns.
module tb_ram_arbiter;

    localparam int LIM = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       p_valid, p_we, l_req, l_we;
    logic [7:0] p_addr, p_wdata, l_addr, l_wdata;
    logic       l_gnt, l_rvalid, ram_we, stall;
    logic [7:0] l_rdata, ram_addr, ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    ram_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rdata(l_rdata), .l_rvalid(l_rvalid),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .stall(stall)
    );

    function automatic logic [7:0] rom_val(input logic [7:0] a);
        if (a == 8'h3C) return 8'hA5;
        return (a ^ 8'h5A) + 8'd17;
    endfunction

    assign ram_rdata = rom_val(ram_addr);

    typedef struct {
        logic       p_valid, p_we;
        logic [7:0] p_addr, p_wdata;
        logic       l_req, l_we;
        logic [7:0] l_addr, l_wdata;
        logic       e_gnt, e_stall, e_we;
        logic [7:0] e_addr, e_wdata;
    } vec_t;

    int         nvec = 0;
    int         nerr = 0;
    logic [7:0] sb[$];
    logic [7:0] last_rdata = 8'd0;
    vec_t       tbl[15];

    function automatic vec_t mk(input logic pv, pwe, input logic [7:0] pa, pd,
                                input logic lr, lwe, input logic [7:0] la, ld,
                                input logic g, st, rwe, input logic [7:0] ra, rd);
        vec_t v;
        v.p_valid = pv; v.p_we = pwe; v.p_addr = pa; v.p_wdata = pd;
        v.l_req = lr; v.l_we = lwe; v.l_addr = la; v.l_wdata = ld;
        v.e_gnt = g; v.e_stall = st; v.e_we = rwe; v.e_addr = ra; v.e_wdata = rd;
        return v;
    endfunction

    // Both requesters active; the loader slot falls every LIM+1 cycles with the guard
    function automatic vec_t mk_both(input int k);
        logic slot;
        slot = GUARD && (k % (LIM + 1) == 0);
        return mk(1, 1, 8'h21, 8'h6D, 1, 0, 8'h3C, 8'h00,
                  slot, slot, !slot, slot ? 8'h3C : 8'h21, slot ? 8'h00 : 8'h6D);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check_ret(input string name);
        logic [7:0] e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({name, " l_rvalid"}, {7'd0, l_rvalid}, 8'd1);
            check({name, " l_rdata"}, l_rdata, e);
            last_rdata = e;
        end else begin
            check({name, " l_rvalid"}, {7'd0, l_rvalid}, 8'd0);
            check({name, " l_rdata hold"}, l_rdata, last_rdata);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        check_ret(name);
        p_valid = v.p_valid; p_we = v.p_we; p_addr = v.p_addr; p_wdata = v.p_wdata;
        l_req = v.l_req; l_we = v.l_we; l_addr = v.l_addr; l_wdata = v.l_wdata;
        #2;
        $display("vec %s: gnt=%0b stall=%0b we=%0b addr=%02h wdata=%02h", name,
                 l_gnt, stall, ram_we, ram_addr, ram_wdata);
        check({name, " l_gnt"}, {7'd0, l_gnt}, {7'd0, v.e_gnt});
        check({name, " stall"}, {7'd0, stall}, {7'd0, v.e_stall});
        check({name, " ram_we"}, {7'd0, ram_we}, {7'd0, v.e_we});
        check({name, " ram_addr"}, ram_addr, v.e_addr);
        check({name, " ram_wdata"}, ram_wdata, v.e_wdata);
        if (v.e_gnt && !v.l_we) sb.push_back(rom_val(v.l_addr));
    endtask

    task automatic step(input vec_t v, input string name);
        @(negedge clk);
        apply(v, name);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " l_gnt"}, {7'd0, l_gnt}, 8'd0);
        check({name, " stall"}, {7'd0, stall}, 8'd0);
        check({name, " ram_we"}, {7'd0, ram_we}, 8'd0);
        check({name, " ram_addr"}, ram_addr, 8'd0);
        check({name, " ram_wdata"}, ram_wdata, 8'd0);
        check({name, " l_rvalid"}, {7'd0, l_rvalid}, 8'd0);
        check({name, " l_rdata"}, l_rdata, 8'd0);
    endtask

    initial begin
        p_valid = 1; p_we = 1; p_addr = 8'h55; p_wdata = 8'h66;
        l_req = 1; l_we = 0; l_addr = 8'h3C; l_wdata = 8'h00;
        #1 rst = 1'b1;
        #6;
        check_all_zero("reset");

        // Release: first cycle sees both requesters from IDLE, pipeline wins
        @(negedge clk);
        rst = 1'b0;
        apply(mk_both(1), "post_reset");
        step(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h3C, 8'h00, 1, 0, 0, 8'h3C, 8'h00), "wait_grant");

        tbl[0]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        tbl[1]  = mk(0, 0, 8'h55, 8'h99, 1, 0, 8'h3C, 8'h11, 1, 0, 0, 8'h3C, 8'h00);
        tbl[2]  = mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h5E, 1, 0, 1, 8'h20, 8'h5E);
        tbl[3]  = mk(1, 0, 8'h44, 8'h66, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h44, 8'h00);
        tbl[4]  = mk(1, 1, 8'h12, 8'h34, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h12, 8'h34);
        tbl[5]  = mk(1, 1, 8'h10, 8'h77, 1, 0, 8'h81, 8'h22, 0, 0, 1, 8'h10, 8'h77);
        tbl[6]  = mk(0, 1, 8'h10, 8'h77, 1, 0, 8'h81, 8'h22, 1, 0, 0, 8'h81, 8'h00);
        tbl[7]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00, 1, 0, 0, 8'h02, 8'h00);
        tbl[8]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'hFF, 8'h00, 1, 0, 0, 8'hFF, 8'h00);
        tbl[9]  = mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h00, 8'hAB, 1, 0, 1, 8'h00, 8'hAB);
        tbl[10] = mk(1, 0, 8'hC3, 8'hFF, 1, 1, 8'h90, 8'hBB, 0, 0, 0, 8'hC3, 8'h00);
        tbl[11] = mk(1, 1, 8'h07, 8'h08, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h07, 8'h08);
        tbl[12] = mk(1, 0, 8'h09, 8'h00, 1, 0, 8'h0A, 8'h00, 0, 0, 0, 8'h09, 8'h00);
        tbl[13] = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h0A, 8'h00, 1, 0, 0, 8'h0A, 8'h00);
        tbl[14] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 15; i++) step(tbl[i], $sformatf("tbl%0d", i));

        // Sustained contention, then the pipeline backs off
        for (int k = 1; k <= 20; k++) step(mk_both(k), $sformatf("starve%0d", k));
        step(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h3C, 8'h00, 1, 0, 0, 8'h3C, 8'h00), "starve_drop");
        step(tbl[0], "starve_idle");

        // Reset pulsed inside the loader slot abandons the access; counting restarts
        for (int k = 1; k <= LIM + 1; k++) step(mk_both(k), $sformatf("pre_rst%0d", k));
        rst = 1'b1;
        #1;
        check("rst_force l_gnt", {7'd0, l_gnt}, 8'd0);
        check("rst_force stall", {7'd0, stall}, 8'd0);
        check("rst_force ram_addr", ram_addr, 8'd0);
        sb.delete();
        last_rdata = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        apply(mk_both(1), "post_rst1");
        for (int k = 2; k <= LIM + 1; k++) step(mk_both(k), $sformatf("post_rst%0d", k));
        step(tbl[0], "final_idle");
        @(negedge clk);
        check_ret("final");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive denied loader cycles before a forced loader slot (legal range 1..7).
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 RESET  in  1  asynchronous active-high reset.
REQ-005 P_VALID  in  1  pipeline MEM stage needs the RAM this cycle.
REQ-006 P_WE  in  1  pipeline access is a write (store); 0 = read (load/branch data).
REQ-007 P_ADDR  in  8  pipeline RAM address; P_WDATA  in  8  pipeline write data.
REQ-008 L_REQ  in  1  loader/debug requester wants one RAM access.
REQ-009 L_WE  in  1; L_ADDR  in  8; L_WDATA  in  8  loader access fields.
REQ-010 L_GNT  out  1  loader access performed this cycle.
REQ-011 L_RDATA  out  8; L_RVALID  out  1  registered loader read return.
REQ-012 RAM_WE  out  1; RAM_ADDR  out  8; RAM_WDATA  out  8  RAM port drive.
REQ-013 RAM_RDATA  in  8  RAM combinational read data.
REQ-014 STALL  out  1  pipeline MEM stage SHALL hold; its access is not performed.

Function
REQ-015 The RAM port SHALL carry at most one access per cycle; the owner's WE/ADDR/WDATA SHALL drive RAM_* combinationally; with no owner RAM_WE, RAM_ADDR, RAM_WDATA SHALL be 0.
REQ-016 A read owner's RAM_WDATA SHALL be 0.
REQ-017 States: IDLE, WAIT (loader denied, counting), FORCE (loader slot, pipeline stalled); 3-bit counter CNT.
REQ-018 IDLE: P_VALID=1 -> pipeline owns; if L_REQ also 1 -> WAIT, CNT=1. P_VALID=0 & L_REQ=1 -> loader owns, L_GNT=1, stay IDLE.
REQ-019 WAIT: P_VALID=0 & L_REQ=1 -> loader owns, L_GNT=1, -> IDLE, CNT=0. Both 1 -> pipeline owns, CNT+1; when CNT+1 = STARVE_LIMIT -> FORCE.
REQ-020 WAIT: L_REQ=0 (protocol violation) -> IDLE, CNT=0, no grant.
REQ-021 FORCE: STALL=1, L_GNT=1, loader owns regardless of P_VALID; next state IDLE, CNT=0; FORCE SHALL last exactly one cycle.
REQ-022 STALL SHALL be 1 only in FORCE; L_GNT and pipeline ownership SHALL never be 1 in the same cycle.
REQ-023 Loader handshake: L_REQ and fields SHALL remain stable until the L_GNT cycle; the loader may drop or change L_REQ the cycle after.
REQ-024 Loader read (L_GNT=1, L_WE=0): L_RDATA SHALL register RAM_RDATA at that edge and L_RVALID SHALL be 1 for exactly the following cycle; write grants SHALL not assert L_RVALID.
REQ-025 L_RDATA SHALL hold its value until the next loader read.
REQ-026 Back-to-back loader requests with P_VALID=0 SHALL be granted every cycle (1 access/cycle throughput).
REQ-027 With L_REQ held and P_VALID held 1, the loader SHALL be granted every STARVE_LIMIT+1 cycles.

Reset
REQ-028 RESET=1 SHALL immediately force state IDLE, CNT=0, L_RDATA=0, L_RVALID=0, and combinationally L_GNT=0, STALL=0, RAM_WE=0, RAM_ADDR=0, RAM_WDATA=0.
REQ-029 RESET mid-WAIT or mid-FORCE SHALL abandon the pending loader access with no grant; the first post-reset cycle evaluates from IDLE.

Configuration
REQ-030 Macro ARB_STARVE_GUARD_EN defined: WAIT/FORCE, CNT and STALL operate per REQ-017..REQ-022.
REQ-031 ARB_STARVE_GUARD_EN undefined: no FORCE state or counter; loader granted only when P_VALID=0; STALL tied 0; all other behaviour unchanged.

Verification
REQ-032 Reset: assert RESET with L_REQ=1, P_VALID=1 -> all outputs 0; release -> next cycle pipeline owns, state WAIT.
REQ-033 Idle loader read: P_VALID=0, L_REQ=1, L_WE=0, L_ADDR=0x3C, RAM_RDATA=0xA5 -> L_GNT=1, RAM_ADDR=0x3C, RAM_WE=0; next cycle L_RVALID=1, L_RDATA=0xA5.
REQ-034 Pipeline store priority: P_VALID=1, P_WE=1, P_ADDR=0x10, P_WDATA=0x77, L_REQ=1 -> RAM_WE=1, RAM_ADDR=0x10, RAM_WDATA=0x77, L_GNT=0.
REQ-035 Starvation (macro defined, STARVE_LIMIT=4): P_VALID=1 and L_REQ=1 held -> pipeline owns cycles 1-4, cycle 5 STALL=1, L_GNT=1, RAM_ADDR=L_ADDR; cycle 6 pipeline owns.
REQ-036 Same stimulus, macro undefined -> L_GNT=0 and STALL=0 for 20 cycles; drop P_VALID -> L_GNT=1 that cycle.
REQ-037 Reset during FORCE: pulse RESET in the FORCE cycle -> L_GNT=0, STALL=0, L_RVALID=0 next cycle, CNT restarts from 0.
